// File: rtl/reg_select_mux_if.sv
// reg_select_mux_if: input-side select/request bus and output-side valid/ready bus of reg_select_mux
interface reg_select_mux_if #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic [NUM_IN-1:0]       in_req;
    logic                    in_ready;
    logic [NUM_IN-1:0]       in_ack;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    modport master (
        output in_data, sel, in_valid, in_req, out_ready,
        input  in_ready, in_ack, out_data, out_src, out_valid, sel_err
    );
    modport slave (
        input  in_data, sel, in_valid, in_req, out_ready,
        output in_ready, in_ack, out_data, out_src, out_valid, sel_err
    );
endinterface

// File: rtl/reg_select_mux.sv
// reg_select_mux: N-input select mux with a one-entry registered output stage, index or round-robin select
module reg_select_mux #(
    parameter int WIDTH   = 5,
    parameter int NUM_IN  = 4,
    parameter int SEL_W   = 2,
    parameter int RR_MODE = 0
) (
    input logic             clk,
    input logic             rst,
    reg_select_mux_if.slave bus
);
    logic [WIDTH-1:0]  out_data_q, out_data_d, mux_data;
    logic [SEL_W-1:0]  out_src_q, out_src_d, rr_ptr_q, rr_ptr_d, grant, hi_g, lo_g;
    logic              out_valid_q, out_valid_d, sel_err_q, sel_err_d;
    logic              hi_hit, sel_ok, accept;
    logic [NUM_IN-1:0] ack;

    // hi_g: lowest requester at or above rr_ptr; lo_g: lowest requester overall (wrap case)
    always_comb begin
        hi_hit = 1'b0;
        hi_g   = '0;
        lo_g   = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (bus.in_req[i] && SEL_W'(i) >= rr_ptr_q) begin
                hi_hit = 1'b1;
                hi_g   = SEL_W'(i);
            end
            if (bus.in_req[i])
                lo_g = SEL_W'(i);
        end
    end

    assign grant        = (RR_MODE != 0) ? (hi_hit ? hi_g : lo_g) : bus.sel;
    assign sel_ok       = (RR_MODE != 0) || (int'(bus.sel) < NUM_IN);
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_ready && ((RR_MODE != 0) ? |bus.in_req : bus.in_valid);

    // an out-of-range index matches no input, giving zero data and no ack
    always_comb begin
        mux_data = '0;
        ack      = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant == SEL_W'(i)) begin
                mux_data = bus.in_data[i*WIDTH +: WIDTH];
                ack[i]   = accept;
            end
        end
    end

    assign bus.in_ack = ack;

    always_comb begin
        out_valid_d = accept || (out_valid_q && !bus.out_ready);
        out_data_d  = accept ? mux_data : out_data_q;
        out_src_d   = accept ? grant : out_src_q;
        sel_err_d   = accept && !sel_ok;
        rr_ptr_d    = (RR_MODE != 0 && accept) ? ((grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + 1'b1) : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            sel_err_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            sel_err_q   <= sel_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_reg_select_mux.sv
// tb_reg_select_mux: scoreboard bench covering index mode (4 and 3 inputs) and round-robin mode
module tb_reg_select_mux;
    typedef struct packed {
        logic [4:0] d;
        logic [1:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [4:0] pat [4] = '{5'h03, 5'h15, 5'h0A, 5'h1F};
    logic [3:0] rr_req [7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h9, 4'h9};
    int         rr_exp [7] = '{0, 1, 2, 3, 0, 3, 0};

    always #5 clk = ~clk;

    reg_select_mux_if #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) b0 ();
    reg_select_mux_if #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) b1 ();
    reg_select_mux_if #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) b2 ();

    reg_select_mux #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .RR_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    reg_select_mux #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .RR_MODE(0)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    reg_select_mux #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .RR_MODE(1)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) if (!rst && b0.out_valid && b0.out_ready) begin
        chk("sb0_pending", int'(q0.size() != 0), 1);
        if (q0.size() != 0) begin
            chk("sb0_data", int'(b0.out_data), int'(q0[0].d));
            chk("sb0_src", int'(b0.out_src), int'(q0[0].s));
            void'(q0.pop_front());
        end
    end

    always @(negedge clk) if (!rst && b1.out_valid && b1.out_ready) begin
        chk("sb1_pending", int'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
            chk("sb1_data", int'(b1.out_data), int'(q1[0].d));
            chk("sb1_src", int'(b1.out_src), int'(q1[0].s));
            void'(q1.pop_front());
        end
    end

    always @(negedge clk) if (!rst && b2.out_valid && b2.out_ready) begin
        chk("sb2_pending", int'(q2.size() != 0), 1);
        if (q2.size() != 0) begin
            chk("sb2_data", int'(b2.out_data), int'(q2[0].d));
            chk("sb2_src", int'(b2.out_src), int'(q2[0].s));
            void'(q2.pop_front());
        end
    end

    initial begin
        {b0.in_data, b0.sel, b0.in_valid, b0.in_req, b0.out_ready} = '0;
        {b1.in_data, b1.sel, b1.in_valid, b1.in_req, b1.out_ready} = '0;
        {b2.in_data, b2.sel, b2.in_valid, b2.in_req, b2.out_ready} = '0;
        tick;
        tick;
        rst = 1'b0;
        // reset discards a held entry even with in_valid asserted
        b0.in_data  = {5'h1F, 5'h0A, 5'h15, 5'h03};
        b0.sel      = 2'd1;
        b0.in_valid = 1'b1;
        q0.push_back('{d: 5'h15, s: 2'd1});
        tick;
        chk("t1_held_valid", int'(b0.out_valid), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        b0.in_valid = 1'b0;
        q0.delete();
        #1;
        chk("t1_rst_valid", int'(b0.out_valid), 0);
        chk("t1_rst_data", int'(b0.out_data), 0);
        chk("t1_rst_src", int'(b0.out_src), 0);
        chk("t1_rst_err", int'(b0.sel_err), 0);
        // index select with pass-through consumer
        b0.sel       = 2'd2;
        b0.in_valid  = 1'b1;
        b0.out_ready = 1'b1;
        #1;
        chk("t2_ack", int'(b0.in_ack), 4'b0100);
        chk("t2_ready", int'(b0.in_ready), 1);
        q0.push_back('{d: 5'h0A, s: 2'd2});
        tick;
        b0.in_valid = 1'b0;
        chk("t2_valid", int'(b0.out_valid), 1);
        chk("t2_data", int'(b0.out_data), 5'h0A);
        chk("t2_src", int'(b0.out_src), 2);
        chk("t2_err", int'(b0.sel_err), 0);
        tick;
        chk("t2_drained", int'(b0.out_valid), 0);
        // stall: inputs wander while the held entry must not move
        b0.sel       = 2'd3;
        b0.in_valid  = 1'b1;
        b0.out_ready = 1'b0;
        q0.push_back('{d: 5'h1F, s: 2'd3});
        tick;
        for (int i = 0; i < 3; i++) begin
            b0.in_data = 20'($urandom);
            b0.sel     = 2'($urandom);
            #1;
            chk("t3_stall_ready", int'(b0.in_ready), 0);
            chk("t3_stall_ack", int'(b0.in_ack), 0);
            tick;
            chk("t3_hold_valid", int'(b0.out_valid), 1);
            chk("t3_hold_data", int'(b0.out_data), 5'h1F);
            chk("t3_hold_src", int'(b0.out_src), 3);
        end
        b0.in_data   = {5'h1F, 5'h0A, 5'h15, 5'h03};
        b0.sel       = 2'd0;
        b0.out_ready = 1'b1;
        #1;
        chk("t3_release_ack", int'(b0.in_ack), 4'b0001);
        chk("t3_release_ready", int'(b0.in_ready), 1);
        q0.push_back('{d: 5'h03, s: 2'd0});
        tick;
        b0.in_valid = 1'b0;
        chk("t3_reload_valid", int'(b0.out_valid), 1);
        chk("t3_reload_data", int'(b0.out_data), 5'h03);
        tick;
        // out-of-range select on a 3-input mux
        b1.in_data   = {5'h0A, 5'h15, 5'h03};
        b1.sel       = 2'd3;
        b1.in_valid  = 1'b1;
        b1.out_ready = 1'b1;
        #1;
        chk("t4_bad_ack", int'(b1.in_ack), 0);
        chk("t4_bad_ready", int'(b1.in_ready), 1);
        q1.push_back('{d: 5'h00, s: 2'd3});
        tick;
        b1.in_valid = 1'b0;
        chk("t4_err_set", int'(b1.sel_err), 1);
        chk("t4_valid", int'(b1.out_valid), 1);
        chk("t4_data", int'(b1.out_data), 0);
        chk("t4_src", int'(b1.out_src), 3);
        tick;
        chk("t4_err_clear", int'(b1.sel_err), 0);
        b1.sel      = 2'd2;
        b1.in_valid = 1'b1;
        #1;
        chk("t4_good_ack", int'(b1.in_ack), 3'b100);
        q1.push_back('{d: 5'h0A, s: 2'd2});
        tick;
        b1.in_valid = 1'b0;
        chk("t4_good_err", int'(b1.sel_err), 0);
        chk("t4_idx4_err", int'(b0.sel_err), 0);
        tick;
        // round-robin rotation then wrap with sparse requests
        b2.in_data   = {pat[3], pat[2], pat[1], pat[0]};
        b2.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            b2.in_req = rr_req[k];
            #1;
            chk("t5_rr_ack", int'(b2.in_ack), 1 << rr_exp[k]);
            q2.push_back('{d: pat[rr_exp[k]], s: 2'(rr_exp[k])});
            tick;
            chk("t5_rr_src", int'(b2.out_src), rr_exp[k]);
            chk("t5_rr_err", int'(b2.sel_err), 0);
        end
        b2.in_req = 4'b0000;
        tick;
        // round-robin stall keeps the pointer
        b2.in_req    = 4'b0110;
        b2.out_ready = 1'b0;
        #1;
        chk("t6_first_ack", int'(b2.in_ack), 4'b0010);
        q2.push_back('{d: pat[1], s: 2'd1});
        tick;
        for (int i = 0; i < 2; i++) begin
            chk("t6_stall_ack", int'(b2.in_ack), 0);
            chk("t6_stall_ready", int'(b2.in_ready), 0);
            tick;
            chk("t6_stall_src", int'(b2.out_src), 1);
        end
        b2.out_ready = 1'b1;
        #1;
        chk("t6_next_ack", int'(b2.in_ack), 4'b0100);
        q2.push_back('{d: pat[2], s: 2'd2});
        tick;
        b2.in_req = 4'b0000;
        chk("t6_next_src", int'(b2.out_src), 2);
        tick;
        tick;
        chk("sb0_empty", q0.size(), 0);
        chk("sb1_empty", q1.size(), 0);
        chk("sb2_empty", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
